// File: rtl/calc_stack_gen.sv
// rtl/calc_stack_gen.sv - parametrised RPN operand stack with overflow/underflow tracking
module calc_stack_gen #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             op_valid,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] value,
    input  logic             clear_err,
    output logic [WIDTH-1:0] top,
    output logic [WIDTH-1:0] next,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             op_err,
    output logic             overflow,
    output logic             underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_PUSH  = 3'd1;
    localparam logic [2:0] OP_POP   = 3'd2;
    localparam logic [2:0] OP_WRITE = 3'd3;
    localparam logic [2:0] OP_SWAP  = 3'd4;
    localparam logic [2:0] OP_DUP   = 3'd5;
    localparam logic [2:0] OP_BINWB = 3'd6;
    localparam logic [2:0] OP_CLEAR = 3'd7;

    logic [WIDTH-1:0] mem [DEPTH];

    // Index arithmetic is modulo DEPTH; at count==DEPTH the low bits are 0,
    // so base-1 still lands on the last slot.
    logic [AW-1:0] base_idx;
    logic [AW-1:0] top_idx;
    logic [AW-1:0] next_idx;
    logic          is_empty;
    logic          is_full;
    logic          has_two;

    assign base_idx = count[AW-1:0];
    assign top_idx  = base_idx - AW'(1);
    assign next_idx = base_idx - AW'(2);
    assign is_empty = (count == '0);
    assign is_full  = (count == DEPTH_C);
    assign has_two  = (count >= CW'(2));

    logic             wr_a;
    logic             wr_b;
    logic [AW-1:0]    wa_idx;
    logic [AW-1:0]    wb_idx;
    logic [WIDTH-1:0] wa_data;
    logic [WIDTH-1:0] wb_data;
    logic [CW-1:0]    count_nxt;
    logic             fail_cap;
    logic             fail_short;

    always_comb begin
        wr_a       = 1'b0;
        wr_b       = 1'b0;
        wa_idx     = base_idx;
        wb_idx     = next_idx;
        wa_data    = value;
        wb_data    = mem[top_idx];
        count_nxt  = count;
        fail_cap   = 1'b0;
        fail_short = 1'b0;
        if (op_valid) begin
            case (op)
                OP_PUSH: begin
                    if (is_full) begin
                        fail_cap = 1'b1;
                    end else begin
                        wr_a      = 1'b1;
                        wa_idx    = base_idx;
                        wa_data   = value;
                        count_nxt = count + CW'(1);
                    end
                end
                OP_POP: begin
                    if (is_empty) fail_short = 1'b1;
                    else          count_nxt  = count - CW'(1);
                end
                OP_WRITE: begin
                    if (is_empty) begin
                        fail_short = 1'b1;
                    end else begin
                        wr_a    = 1'b1;
                        wa_idx  = top_idx;
                        wa_data = value;
                    end
                end
                OP_SWAP: begin
                    if (!has_two) begin
                        fail_short = 1'b1;
                    end else begin
                        wr_a    = 1'b1;
                        wa_idx  = top_idx;
                        wa_data = mem[next_idx];
                        wr_b    = 1'b1;
                        wb_idx  = next_idx;
                        wb_data = mem[top_idx];
                    end
                end
                OP_DUP: begin
                    // Empty takes precedence: DUP cannot be both empty and full.
                    if (is_empty) begin
                        fail_short = 1'b1;
                    end else if (is_full) begin
                        fail_cap = 1'b1;
                    end else begin
                        wr_a      = 1'b1;
                        wa_idx    = base_idx;
                        wa_data   = mem[top_idx];
                        count_nxt = count + CW'(1);
                    end
                end
                OP_BINWB: begin
                    if (!has_two) begin
                        fail_short = 1'b1;
                    end else begin
                        wr_a      = 1'b1;
                        wa_idx    = next_idx;
                        wa_data   = value;
                        count_nxt = count - CW'(1);
                    end
                end
                OP_CLEAR: count_nxt = '0;
                OP_NOP:   count_nxt = count;
                default:  count_nxt = count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count     <= '0;
            op_err    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            count     <= count_nxt;
            op_err    <= fail_cap | fail_short;
            overflow  <= (overflow & ~clear_err) | fail_cap;
            underflow <= (underflow & ~clear_err) | fail_short;
        end
    end

    // Storage is never reset; visibility is governed solely by count.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (wr_a) mem[wa_idx] <= wa_data;
            if (wr_b) mem[wb_idx] <= wb_data;
        end
    end

    assign top   = is_empty ? '0 : mem[top_idx];
    assign next  = has_two ? mem[next_idx] : '0;
    assign empty = is_empty;
    assign full  = is_full;

endmodule

// File: tb/tb_calc_stack_gen.sv
// tb/tb_calc_stack_gen.sv - checks calc_stack_gen at 32x64 and 8x4 against a reference model
module tb_calc_stack_gen;

    logic        clock = 1'b0;
    logic        reset;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] value;
    logic        clear_err;

    logic [31:0] top_b, next_b;
    logic [6:0]  count_b;
    logic        empty_b, full_b, err_b, ovf_b, unf_b;
    logic [7:0]  top_s, next_s;
    logic [2:0]  count_s;
    logic        empty_s, full_s, err_s, ovf_s, unf_s;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    calc_stack_gen #(.WIDTH(32), .DEPTH(64)) dut_big (
        .clock(clock), .reset(reset), .op_valid(op_valid), .op(op), .value(value),
        .clear_err(clear_err), .top(top_b), .next(next_b), .count(count_b),
        .empty(empty_b), .full(full_b), .op_err(err_b), .overflow(ovf_b), .underflow(unf_b)
    );

    calc_stack_gen #(.WIDTH(8), .DEPTH(4)) dut_small (
        .clock(clock), .reset(reset), .op_valid(op_valid), .op(op), .value(value[7:0]),
        .clear_err(clear_err), .top(top_s), .next(next_s), .count(count_s),
        .empty(empty_s), .full(full_s), .op_err(err_s), .overflow(ovf_s), .underflow(unf_s)
    );

    // Reference model state, index 0 = 32x64, index 1 = 8x4
    logic [31:0] m_mem [2][64];
    int          m_cnt [2];
    logic        m_err [2];
    logic        m_ovf [2];
    logic        m_unf [2];
    int          m_dep [2] = '{64, 4};
    logic [31:0] m_msk [2] = '{32'hFFFF_FFFF, 32'h0000_00FF};

    typedef struct {
        int          inst;
        int          cnt;
        logic [31:0] top;
        logic [31:0] nxt;
        logic        empty, full, err, ovf, unf;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic        v;
        logic [2:0]  op;
        logic [31:0] val;
        logic        ce;
        int          cnt;
        logic [31:0] top, nxt;
        logic        full, err, ovf, unf;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic model_step(input int i, input logic r, input logic v, input logic [2:0] o,
                              input logic [31:0] val, input logic ce);
        int   n;
        logic fo, fu;
        logic [31:0] tmp;
        n  = m_cnt[i];
        fo = 1'b0;
        fu = 1'b0;
        if (r) begin
            m_cnt[i] = 0; m_err[i] = 0; m_ovf[i] = 0; m_unf[i] = 0;
            return;
        end
        if (v) begin
            case (o)
                3'd1: if (n >= m_dep[i]) fo = 1; else begin m_mem[i][n] = val & m_msk[i]; n++; end
                3'd2: if (n < 1) fu = 1; else n--;
                3'd3: if (n < 1) fu = 1; else m_mem[i][n-1] = val & m_msk[i];
                3'd4: if (n < 2) fu = 1;
                      else begin
                          tmp = m_mem[i][n-1]; m_mem[i][n-1] = m_mem[i][n-2]; m_mem[i][n-2] = tmp;
                      end
                3'd5: if (n < 1) fu = 1; else if (n >= m_dep[i]) fo = 1;
                      else begin m_mem[i][n] = m_mem[i][n-1]; n++; end
                3'd6: if (n < 2) fu = 1; else begin m_mem[i][n-2] = val & m_msk[i]; n--; end
                3'd7: n = 0;
                default: ;
            endcase
        end
        m_cnt[i] = n;
        m_err[i] = fo | fu;
        m_ovf[i] = (m_ovf[i] & ~ce) | fo;
        m_unf[i] = (m_unf[i] & ~ce) | fu;
    endtask

    task automatic step(input logic r, input logic v, input logic [2:0] o,
                        input logic [31:0] val, input logic ce);
        exp_t e;
        reset = r; op_valid = v; op = o; value = val; clear_err = ce;
        for (int i = 0; i < 2; i++) begin
            model_step(i, r, v, o, val, ce);
            e.inst  = i;
            e.cnt   = m_cnt[i];
            e.top   = (m_cnt[i] >= 1) ? m_mem[i][m_cnt[i]-1] : 32'h0;
            e.nxt   = (m_cnt[i] >= 2) ? m_mem[i][m_cnt[i]-2] : 32'h0;
            e.empty = (m_cnt[i] == 0);
            e.full  = (m_cnt[i] == m_dep[i]);
            e.err   = m_err[i];
            e.ovf   = m_ovf[i];
            e.unf   = m_unf[i];
            sb.push_back(e);
        end
        @(posedge clock);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.inst == 0) begin
                chk("big.count", 32'(count_b), 32'(e.cnt));
                chk("big.top", top_b, e.top);
                chk("big.next", next_b, e.nxt);
                chk("big.flags", {27'b0, empty_b, full_b, err_b, ovf_b, unf_b},
                    {27'b0, e.empty, e.full, e.err, e.ovf, e.unf});
            end else begin
                chk("small.count", 32'(count_s), 32'(e.cnt));
                chk("small.top", 32'(top_s), e.top);
                chk("small.next", 32'(next_s), e.nxt);
                chk("small.flags", {27'b0, empty_s, full_s, err_s, ovf_s, unf_s},
                    {27'b0, e.empty, e.full, e.err, e.ovf, e.unf});
            end
        end
    endtask

    task automatic addv(input logic v, input logic [2:0] o, input logic [31:0] val, input logic ce,
                        input int cnt, input logic [31:0] t, input logic [31:0] nx,
                        input logic fl, input logic er, input logic ov, input logic un);
        vec_t x;
        x.v = v; x.op = o; x.val = val; x.ce = ce; x.cnt = cnt; x.top = t; x.nxt = nx;
        x.full = fl; x.err = er; x.ovf = ov; x.unf = un;
        tbl.push_back(x);
    endtask

    initial begin
        int r;
        logic [2:0] ro;
        reset = 1'b1; op_valid = 1'b0; op = 3'd0; value = '0; clear_err = 1'b0;
        #1;
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("reset.count", 32'(count_s), 32'd0);
        chk("reset.outs", {top_s, next_s, 3'b0, empty_s, full_s, err_s, ovf_s, unf_s},
            {8'h0, 8'h0, 3'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});

        //    v  op    value  ce  cnt top    next   full err ovf unf   (8x4 expectations)
        addv(1, 3'd1, 32'h05, 0, 1, 32'h05, 32'h00, 0, 0, 0, 0);
        addv(1, 3'd1, 32'h07, 0, 2, 32'h07, 32'h05, 0, 0, 0, 0);
        addv(1, 3'd4, 32'h00, 0, 2, 32'h05, 32'h07, 0, 0, 0, 0);
        addv(1, 3'd6, 32'h0C, 0, 1, 32'h0C, 32'h00, 0, 0, 0, 0);
        addv(1, 3'd7, 32'h00, 0, 0, 32'h00, 32'h00, 0, 0, 0, 0);
        addv(1, 3'd2, 32'h00, 0, 0, 32'h00, 32'h00, 0, 1, 0, 1);
        addv(1, 3'd3, 32'h03, 0, 0, 32'h00, 32'h00, 0, 1, 0, 1);
        addv(1, 3'd0, 32'h00, 1, 0, 32'h00, 32'h00, 0, 0, 0, 0);
        addv(1, 3'd1, 32'h01, 0, 1, 32'h01, 32'h00, 0, 0, 0, 0);
        addv(1, 3'd1, 32'h02, 0, 2, 32'h02, 32'h01, 0, 0, 0, 0);
        addv(1, 3'd1, 32'h03, 0, 3, 32'h03, 32'h02, 0, 0, 0, 0);
        addv(1, 3'd1, 32'h04, 0, 4, 32'h04, 32'h03, 1, 0, 0, 0);
        addv(1, 3'd1, 32'h09, 0, 4, 32'h04, 32'h03, 1, 1, 1, 0);
        addv(0, 3'd1, 32'h4D, 0, 4, 32'h04, 32'h03, 1, 0, 1, 0);
        addv(1, 3'd5, 32'h00, 0, 4, 32'h04, 32'h03, 1, 1, 1, 0);
        addv(1, 3'd2, 32'h00, 0, 3, 32'h03, 32'h02, 0, 0, 1, 0);
        addv(1, 3'd7, 32'h00, 1, 0, 32'h00, 32'h00, 0, 0, 0, 0);
        addv(1, 3'd1, 32'hAA, 0, 1, 32'hAA, 32'h00, 0, 0, 0, 0);
        addv(1, 3'd5, 32'h00, 0, 2, 32'hAA, 32'hAA, 0, 0, 0, 0);
        addv(1, 3'd3, 32'h55, 0, 2, 32'h55, 32'hAA, 0, 0, 0, 0);
        addv(1, 3'd7, 32'h00, 0, 0, 32'h00, 32'h00, 0, 0, 0, 0);
        addv(1, 3'd2, 32'h00, 1, 0, 32'h00, 32'h00, 0, 1, 0, 1);

        for (int k = 0; k < tbl.size(); k++) begin
            step(0, tbl[k].v, tbl[k].op, tbl[k].val, tbl[k].ce);
            chk($sformatf("vec%0d.count", k), 32'(count_s), 32'(tbl[k].cnt));
            chk($sformatf("vec%0d.top", k), 32'(top_s), tbl[k].top);
            chk($sformatf("vec%0d.next", k), 32'(next_s), tbl[k].nxt);
            chk($sformatf("vec%0d.flags", k), {28'b0, full_s, err_s, ovf_s, unf_s},
                {28'b0, tbl[k].full, tbl[k].err, tbl[k].ovf, tbl[k].unf});
        end

        // Op presented during reset is discarded and sticky flags are wiped
        step(0, 1, 3'd1, 32'h11, 0);
        step(1, 1, 3'd1, 32'h33, 0);
        chk("rstop.count", {25'b0, count_b}, 32'd0);
        chk("rstop.flags", {26'b0, err_s, ovf_s, unf_s, err_b, ovf_b, unf_b}, 32'd0);
        step(0, 0, 3'd0, 0, 0);
        chk("rstop.after", {count_s, top_s, next_s}, 19'd0);

        // Fill the deep stack to its limit and beyond
        for (int k = 0; k < 70; k++) step(0, 1, 3'd1, $urandom, 0);
        chk("deep.full", {30'b0, full_b, ovf_b}, 32'd3);
        step(0, 1, 3'd5, 0, 0);
        chk("deep.dup_full", {30'b0, err_b, ovf_b}, 32'd3);

        // Random back-to-back mix, every cycle checked against the model
        for (int k = 0; k < 3000; k++) begin
            r = $urandom_range(0, 99);
            if      (r < 35) ro = 3'd1;
            else if (r < 50) ro = 3'd2;
            else if (r < 58) ro = 3'd3;
            else if (r < 68) ro = 3'd4;
            else if (r < 78) ro = 3'd5;
            else if (r < 90) ro = 3'd6;
            else if (r < 92) ro = 3'd7;
            else             ro = 3'd0;
            step($urandom_range(0, 499) == 0, $urandom_range(0, 9) != 0, ro, $urandom,
                 $urandom_range(0, 15) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/calc_stack_gen.md
# calc_stack_gen

Parametrised operand stack for the RPN calculator datapath, the successor to the fixed 32x64 stack. It holds up to DEPTH words of WIDTH bits and executes one encoded operation per cycle: push, pop, update-top, swap, dup, binary-op writeback and clear. It exposes the top two entries to the ALU and reports overflow and underflow through sticky flags and a per-operation error pulse. It sits between the key decoder/controller and the ALU.

## Interface
- WIDTH, 32, data word width in bits (>=1)
- DEPTH, 64, maximum number of entries; power of two, >=4
- CW, $clog2(DEPTH)+1, count width (derived, not overridable)
- clock  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high; clock clock
- op_valid  in  1  execute op this cycle
- op  in  3  0 NOP, 1 PUSH, 2 POP, 3 WRITE, 4 SWAP, 5 DUP, 6 BINWB, 7 CLEAR
- value  in  WIDTH  operand for PUSH, WRITE, BINWB
- clear_err  in  1  clear sticky error flags
- top  out  WIDTH  entry at top of stack; 0 when count==0
- next  out  WIDTH  entry below top; 0 when count<2
- count  out  CW  number of valid entries, 0..DEPTH
- empty  out  1  count==0
- full  out  1  count==DEPTH
- op_err  out  1  one-cycle pulse: previous accepted op was rejected
- overflow  out  1  sticky: a rejected op would have exceeded DEPTH
- underflow  out  1  sticky: a rejected op needed more entries than present

## Operation
- State: memory[DEPTH] of WIDTH bits, count register (CW bits), flag registers. Memory contents are not reset; top/next are masked to 0 by count, never by memory contents.
- Let n = count before the op. Ops (only when op_valid=1):
  - PUSH: requires n<DEPTH; mem[n]=value; count=n+1.
  - POP: requires n>=1; count=n-1.
  - WRITE: requires n>=1; mem[n-1]=value; count unchanged.
  - SWAP: requires n>=2; exchange mem[n-1] and mem[n-2].
  - DUP: requires 1<=n<DEPTH; mem[n]=mem[n-1]; count=n+1.
  - BINWB: requires n>=2; mem[n-2]=value; count=n-1 (two operands replaced by result).
  - CLEAR: count=0; never fails.
  - NOP: no effect.
- Rejected op: no change to memory or count; op_err pulses; overflow set if failure was capacity (PUSH at full, DUP at full), else underflow set (POP/WRITE/DUP at empty, SWAP/BINWB with n<2).
- op_valid=0: no state change; op ignored.
- clear_err clears both sticky flags; if the same cycle raises an error, the new flag is set (set wins).
- Counts are unsigned; count never wraps, no pointer arithmetic beyond 0..DEPTH.

## Timing
- Reset values: count=0, empty=1, full=0, top=0, next=0, op_err=0, overflow=0, underflow=0.
- reset has priority over op_valid and clear_err; an op presented during reset is discarded.
- Single-cycle ops: state updated at the edge where op_valid=1; top, next, count, empty, full reflect the result in the following cycle (combinational read of registered state).
- op_err asserted exactly the cycle after the rejected op, for one cycle; back-to-back rejections give consecutive pulses.
- Ops may be issued every cycle; no ready/backpressure.
- value sampled only at the accepting edge.

## Test plan
- Reset, then PUSH 5, PUSH 7 -> count=2, top=7, next=5; SWAP -> top=5, next=7; BINWB value=12 -> count=1, top=12, next=0.
- From reset, POP -> op_err pulse one cycle, underflow=1, count=0; WRITE 3 -> underflow stays 1; clear_err -> underflow=0.
- DEPTH=4, WIDTH=8: PUSH 1,2,3,4 -> full=1; PUSH 9 -> overflow=1, top=4, count=4; DUP -> second op_err pulse, no change; POP -> full=0, top=3.
- PUSH 0xAA, DUP, WRITE 0x55 -> top=0x55, next=0xAA, count=2; CLEAR -> count=0, top=0, next=0, empty=1.
- clear_err asserted in the same cycle as a failing POP on empty -> underflow=1 after the edge; reset asserted with op_valid=1, PUSH -> count=0, all flags 0.
- Back-to-back ops every cycle, random mix vs. a reference model at WIDTH=32/DEPTH=64 and WIDTH=8/DEPTH=4 -> top/next/count/flags match each cycle.
